// File: rtl/riscv_mem_pkg.sv
// Shared types, limits and the request legality check for the M-stage
// data-memory responder.
package riscv_mem_pkg;

  localparam int unsigned LATENCY_MAX = 7;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } f3_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Legal size code for the direction and naturally aligned for that size.
  function automatic logic access_ok(input logic [2:0] f3,
                                     input logic       is_store,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store byte enables and lane replication, and load
// lane selection with sign/zero extension.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_lanes_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o    = 4'b1111;
    st_lanes_o = st_data_i;
    case (st_f3_i)
      F3_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_lanes_o = {4{st_data_i[7:0]}};
      end
      F3_H: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_lanes_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off_i)
      2'd0:    ld_byte = ld_word_i[7:0];
      2'd1:    ld_byte = ld_word_i[15:8];
      2'd2:    ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data-memory responder: accepts one load/store at a time, waits a
// programmable number of cycles under stall, then commits against a byte-lane word array.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        AccessErrM,
  output logic        ErrSeenM
);

  localparam int unsigned       AW      = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  LAT_CNT = CNT_W'(LATENCY);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [AW+1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic              store_q;

  logic [31:0]       rdata_q;
  logic [2:0]        ld_f3_q;
  logic [1:0]        ld_off_q;
  logic              err_seen_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              req, req_ok, in_idle, accept, access_err, commit;
  logic [AW+1:0]     c_addr;
  logic [AW-1:0]     c_idx;
  logic [31:0]       c_wdata;
  logic [2:0]        c_f3;
  logic              c_store;
  logic [3:0]        st_be;
  logic [31:0]       st_lanes;
  logic              unused_addr_hi;

  // Address bits above the array index are deliberately don't-care (wrap).
  assign unused_addr_hi = ^ALUResultM[31:AW+2];

  assign req        = MemReadM | MemWriteM;
  assign req_ok     = access_ok(funct3M, MemWriteM, ALUResultM[1:0]);
  assign in_idle    = (state_q == ST_IDLE);
  assign accept     = in_idle & req & req_ok;
  assign access_err = in_idle & req & ~req_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = LAT_CNT;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero latency the commit happens on the accepting edge, so the live
  // request fields feed the array instead of the capture registers.
  assign c_addr  = in_idle ? ALUResultM[AW+1:0] : addr_q;
  assign c_wdata = in_idle ? WriteDataM         : wdata_q;
  assign c_f3    = in_idle ? funct3M            : f3_q;
  assign c_store = in_idle ? MemWriteM          : store_q;
  assign c_idx   = c_addr[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access_err) err_seen_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      store_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= ALUResultM[AW+1:0];
      wdata_q <= WriteDataM;
      f3_q    <= funct3M;
      store_q <= MemWriteM;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && c_store) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[c_idx][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
  end

  // Load format is latched with the data so ReadDataM holds across stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
    end else if (commit && !c_store) begin
      rdata_q  <= mem_q[c_idx];
      ld_f3_q  <= c_f3;
      ld_off_q <= c_addr[1:0];
    end
  end

  load_store_align u_align (
    .st_f3_i    (c_f3),
    .st_off_i   (c_addr[1:0]),
    .st_data_i  (c_wdata),
    .st_be_o    (st_be),
    .st_lanes_o (st_lanes),
    .ld_f3_i    (ld_f3_q),
    .ld_off_i   (ld_off_q),
    .ld_word_i  (rdata_q),
    .ld_data_o  (ReadDataM)
  );

  assign MemStallM  = rst_n & (accept | (state_q == ST_WAIT));
  assign AccessErrM = rst_n & access_err;
  assign ErrSeenM   = err_seen_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at latencies 0, 3 and 5 with a
// load-data scoreboard.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [2:0]  f3    [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        aerr  [3];
  logic        seen  [3];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      data_mem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (gi == 0 ? 0 : (gi == 1 ? 3 : 5))
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n[gi]),
        .MemReadM   (rd[gi]),
        .MemWriteM  (wr[gi]),
        .funct3M    (f3[gi]),
        .ALUResultM (addr[gi]),
        .WriteDataM (wd[gi]),
        .ReadDataM  (rdata[gi]),
        .MemStallM  (stall[gi]),
        .AccessErrM (aerr[gi]),
        .ErrSeenM   (seen[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One accepted access; loads push their expected result and pop it in RESP.
  task automatic access(input int d, input bit w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] dat,
                        input logic [31:0] exp, input bit hold);
    int n;
    @(negedge clk);
    rd[d] = ~w; wr[d] = w; f3[d] = fn; addr[d] = a; wd[d] = dat;
    if (!w) exp_q.push_back(exp);
    #1;
    n = 0;
    while (stall[d] === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_len", n, lat_of(d) + 1);
    if (!w && exp_q.size() > 0) chk("load_data", rdata[d], exp_q.pop_front());
    if (hold) @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b0;
    #1;
    if (hold) chk("held_once", stall[d], 1'b0);
    $display("txn dut=%0d %s f3=%03b addr=0x%08h wdata=0x%08h rdata=0x%08h stall_cycles=%0d",
             d, w ? "ST" : "LD", fn, a, dat, rdata[d], n);
  endtask

  task automatic bad_access(input int d, input bit w, input logic [2:0] fn,
                            input logic [31:0] a, input logic [31:0] dat);
    @(negedge clk);
    rd[d] = ~w; wr[d] = w; f3[d] = fn; addr[d] = a; wd[d] = dat;
    #1;
    chk("err_pulse", aerr[d], 1'b1);
    chk("err_nostall", stall[d], 1'b0);
    @(negedge clk);
    rd[d] = 1'b0; wr[d] = 1'b0;
    #1;
    chk("err_clear", aerr[d], 1'b0);
    chk("err_seen", seen[d], 1'b1);
    $display("txn dut=%0d %s f3=%03b addr=0x%08h rejected err=%0b",
             d, w ? "ST" : "LD", fn, a, seen[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      f3[d] = 3'b000; addr[d] = '0; wd[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdata", rdata[d], 32'h0);
      chk("rst_stall", stall[d], 1'b0);
      chk("rst_err", aerr[d], 1'b0);
      chk("rst_seen", seen[d], 1'b0);
    end

    // Latency 0: word round trip, byte/half extension, lane merges.
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(0, 1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 0);
    chk("hold_after_store", rdata[0], 32'hDEADBEEF);
    access(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    access(0, 0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
    access(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 0);
    access(0, 0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 0);
    access(0, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0);
    chk("fmt_hold", rdata[0], 32'h000080FF);
    access(0, 1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0, 0);
    access(0, 0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 0);
    access(0, 1, 3'b001, 32'h22, 32'h1234BEEF, 32'h0, 0);
    access(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
    access(0, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFAA, 0);
    access(0, 1, 3'b010, 32'h00, 32'h01234567, 32'h0, 0);

    // Rejected requests leave memory untouched.
    chk("seen_before", seen[0], 1'b0);
    bad_access(0, 0, 3'b001, 32'h01, 32'h0);
    bad_access(0, 1, 3'b010, 32'h02, 32'h55555555);
    bad_access(0, 1, 3'b011, 32'h10, 32'h0);
    bad_access(0, 1, 3'b100, 32'h20, 32'h0);
    access(0, 0, 3'b010, 32'h00, 32'h0, 32'h01234567, 0);
    access(0, 0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 0);
    access(0, 0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 0);
    chk("seen_sticky", seen[0], 1'b1);

    // Latency 3: stall length and a request held through RESP.
    access(1, 1, 3'b010, 32'h40, 32'h0BADF00D, 32'h0, 0);
    access(1, 0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 1);
    @(negedge clk); #1;
    chk("held_idle", stall[1], 1'b0);
    access(1, 0, 3'b101, 32'h42, 32'h0, 32'h00000BAD, 0);

    // Latency 5: reset during WAIT discards the store.
    access(2, 1, 3'b010, 32'h80, 32'h11111111, 32'h0, 0);
    access(2, 0, 3'b010, 32'h80, 32'h0, 32'h11111111, 0);
    @(negedge clk);
    wr[2] = 1'b1; rd[2] = 1'b0; f3[2] = 3'b010; addr[2] = 32'h80; wd[2] = 32'h22222222;
    #1;
    chk("mid_accept_stall", stall[2], 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("mid_wait_stall", stall[2], 1'b1);
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_stall", stall[2], 1'b0);
    chk("mid_rst_rdata", rdata[2], 32'h0);
    wr[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    $display("txn dut=2 ST f3=010 addr=0x00000080 aborted by reset");
    access(2, 0, 3'b010, 32'h80, 32'h0, 32'h11111111, 0);

    // Index wraps modulo the array depth.
    access(2, 1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 0);
    access(2, 0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0);

    chk("sb_empty", exp_q.size(), 0);

    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    chk("seen_cleared", seen[0], 1'b0);
    @(negedge clk);
    rst_n[0] = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-stage data-memory responder for the pipelined RISC-V core. Consumes the registered M-stage request (MemWriteM, MemReadM, ALUResultM, WriteDataM, funct3M) and serves loads and stores against an internal word array with byte lanes. Provides a programmable-latency wait with a stall to the hazard unit, plus an access-error flag. Load data goes to the writeback path.

## Interface
- DEPTH_WORDS, 1024: array depth in 32-bit words (power of two); index width AW = log2(DEPTH_WORDS).
- LATENCY, 1: extra wait cycles per access, range 0..7.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemReadM  in  1  load request.
- MemWriteM  in  1  store request.
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, LSB-aligned.
- ReadDataM  out  32  extended load result.
- MemStallM  out  1  freeze IF/ID/EX/M registers.
- AccessErrM  out  1  single-cycle pulse: misaligned or illegal funct3.
- ErrSeenM  out  1  sticky error flag.

## Operation
- States: IDLE, WAIT, RESP. A request is present when MemReadM or MemWriteM is 1. If both are 1, the request is a store and ReadDataM is not updated.
- Alignment and legality checks:
  - H/HU needs addr[0]=0.
  - W needs addr[1:0]=0.
  - Loads accept funct3 000/001/010/100/101; stores accept 000/001/010. Any other code is illegal.
- IDLE with a legal, aligned request:
  - MemStallM=1 combinationally.
  - Capture address, data, funct3 and direction.
  - Load cnt=LATENCY.
  - Next state is RESP if LATENCY=0, else WAIT.
- IDLE with an illegal or misaligned request:
  - AccessErrM=1 combinationally; ErrSeenM<=1.
  - No array access, no stall, stay IDLE.
- WAIT: MemStallM=1 and cnt decrements. When cnt=1, transition to RESP.
- Access commits on the edge entering RESP:
  - Stores write only the selected byte lanes: SB lane addr[1:0]; SH lanes addr[1]*2..+1; SW all four.
  - Loads register the whole word into rdata_q.
- RESP:
  - MemStallM=0; the pipeline advances at the end of this cycle.
  - The request still present at the inputs is not re-accepted.
  - Next state is IDLE.
- ReadDataM is the lane-selected, extended value of rdata_q per the captured funct3:
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - It holds until the next load commits.
- Array index = addr[AW+1:2]. Upper address bits are ignored, so the index wraps modulo DEPTH_WORDS.
- Array contents are not reset.

## Timing
- Reset values: state IDLE, cnt 0, rdata_q 0, ReadDataM 0, MemStallM 0, AccessErrM 0, ErrSeenM 0.
- MemStallM is high for LATENCY+1 cycles per access; each request occupies LATENCY+2 cycles.
- Load data is valid in the RESP cycle, LATENCY+1 cycles after acceptance.
- Back-to-back requests: the earliest acceptance is the cycle after RESP.
- Reset asserted mid-access (IDLE-accept or WAIT): the uncommitted store is discarded, the FSM returns to IDLE, and all outputs go to their reset values.
- AccessErrM is only meaningful in IDLE. Its inputs are ignored in WAIT and RESP.

## Structure
- riscv_mem_pkg holds:
  - the funct3 size enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - localparam LATENCY_MAX=7.
- One sub-module, load_store_align (combinational). It generates the byte-enable mask, replicates store data onto lanes, and performs load lane-select plus extension.
- The top level holds the FSM, counter, capture registers and array.

## Test plan
- LATENCY=0. SW 0xDEADBEEF to 0x10, then LW 0x10 → MemStallM high 1 cycle per access; ReadDataM=0xDEADBEEF in RESP.
- Array word 0x10 = 0x80FF7F01. Issue LB 0x13, LBU 0x13, LH 0x12, LHU 0x12 → ReadDataM = 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- SB 0xAA to 0x21 over word 0x11223344 → LW 0x20 returns 0x1122AA44; SH 0xBEEF to 0x22 → LW returns 0xBEEFAA44.
- LATENCY=3. LW issued → MemStallM high exactly 4 cycles. A request held through RESP is served once only.
- Misaligned accesses: LH 0x01, SW 0x02, and funct3=011 → AccessErrM pulses 1 cycle each, no stall, memory unchanged, ErrSeenM=1 until reset.
- LATENCY=5. SW issued and rst_n pulsed during WAIT → stall drops immediately and the later LW of that address returns the old value. DEPTH_WORDS=1024: SW to 0x1000 followed by LW 0x0 returns the stored value (wrap-around).
